q6fsm_rr_scheduler: RTL

- Time-multiplexes one six-state w-sequence detector across N_CH independent input streams.
- Round-robin arbiter accepts at most one w sample per cycle via valid/ready.
- Per-channel detector state is held in a state register file; the shared next-state logic updates only the granted channel.
- Emits one registered result (channel id, z) per accepted sample; sits between stream sources and downstream event logic.

---
 rtl/q6fsm_rr_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/q6fsm_rr_scheduler.sv
// Round-robin scheduler sharing one six-state w-sequence detector
// across N_CH streams, one accepted sample per cycle.
module q6fsm_rr_scheduler #(
  parameter int N_CH = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req_valid,
  input  logic [N_CH-1:0] req_w,
  output logic [N_CH-1:0] req_ready,
  input  logic [N_CH-1:0] clr,
  output logic            out_valid,
  output logic [IDW-1:0]  out_ch,
  output logic            out_z,
  output logic [N_CH-1:0] ch_z
);

  localparam logic [2:0] S_A = 3'd0;
  localparam logic [2:0] S_B = 3'd1;
  localparam logic [2:0] S_C = 3'd2;
  localparam logic [2:0] S_D = 3'd3;
  localparam logic [2:0] S_E = 3'd4;
  localparam logic [2:0] S_F = 3'd5;

  logic [2:0]     st     [N_CH];
  logic [2:0]     st_nxt [N_CH];
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] gnt_id;
  logic           accept;
  logic           found;
  logic           res_z;

  function automatic logic [2:0] next_st(
    input logic [2:0] s,
    input logic       w
  );
    logic [2:0] n;
    case (s)
      S_A:     n = w ? S_A : S_B;
      S_B:     n = w ? S_D : S_C;
      S_C:     n = w ? S_D : S_E;
      S_D:     n = w ? S_A : S_F;
      S_E:     n = w ? S_D : S_E;
      S_F:     n = w ? S_D : S_C;
      default: n = S_A;
    endcase
    return n;
  endfunction

  function automatic logic z_of(input logic [2:0] s);
    return (s == S_E) || (s == S_F);
  endfunction

  // First valid channel at or after ptr, wrapping modulo N_CH.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    found     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_CH)
        idx = idx - N_CH;
      if (!found && !reset && req_valid[idx]) begin
        found          = 1'b1;
        req_ready[idx] = 1'b1;
        gnt_id         = IDW'(idx);
      end
    end
    accept = found;
  end

  always_comb begin
    ptr_nxt = ptr;
    if (accept)
      ptr_nxt = (int'(gnt_id) == N_CH - 1) ? '0 : gnt_id + 1'b1;
  end

  // Clear overrides a same-cycle update on that channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_nxt[i] = st[i];
      if (req_ready[i])
        st_nxt[i] = next_st(st[i], req_w[i]);
      if (clr[i])
        st_nxt[i] = S_A;
    end
  end

  always_comb begin
    res_z = z_of(st_nxt[gnt_id]);
    for (int i = 0; i < N_CH; i++)
      ch_z[i] = z_of(st[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++)
        st[i] <= S_A;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_z     <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        st[i] <= st_nxt[i];
      ptr       <= ptr_nxt;
      out_valid <= accept;
      if (accept) begin
        out_ch <= gnt_id;
        out_z  <= res_z;
      end
    end
  end

endmodule
